// File: rtl/mem_access.sv
// MEM stage of the 5-stage MIPS pipeline: runs loads/stores over a req/ack data bus,
// stalls the pipeline while waiting, and aligns load data for MEM/WB.
module mem_access #(
  parameter int unsigned TIMEOUT        = 255,
  parameter int unsigned EXC_CODE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [7:0]                aluop_i,
  input  logic [31:0]               mem_addr_i,
  input  logic [31:0]               reg2_i,
  input  logic [4:0]                wd_i,
  input  logic                      wreg_i,
  input  logic [31:0]               wdata_i,
  input  logic                      whilo_i,
  input  logic [31:0]               hi_i,
  input  logic [31:0]               lo_i,
  input  logic                      cp0_we_i,
  input  logic [4:0]                cp0_waddr_i,
  input  logic [31:0]               cp0_wdata_i,
  input  logic [EXC_CODE_WIDTH-1:0] exc_code_i,
  input  logic [31:0]               exc_epc_i,
  input  logic [31:0]               exc_badvaddr_i,
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [31:0]               bus_addr_o,
  output logic [3:0]                bus_be_o,
  output logic [31:0]               bus_wdata_o,
  input  logic                      bus_ack_i,
  input  logic [31:0]               bus_rdata_i,
  output logic                      stall_req_o,
  output logic [4:0]                wd_o,
  output logic                      wreg_o,
  output logic [31:0]               wdata_o,
  output logic                      whilo_o,
  output logic [31:0]               hi_o,
  output logic [31:0]               lo_o,
  output logic                      cp0_we_o,
  output logic [4:0]                cp0_waddr_o,
  output logic [31:0]               cp0_wdata_o,
  output logic [EXC_CODE_WIDTH-1:0] exc_code_o,
  output logic [31:0]               exc_epc_o,
  output logic [31:0]               exc_badvaddr_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = EXC_CODE_WIDTH'(31);
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL = EXC_CODE_WIDTH'(4);
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ADES = EXC_CODE_WIDTH'(5);
  localparam logic [EXC_CODE_WIDTH-1:0] EC_DBE  = EXC_CODE_WIDTH'(7);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        dbe_q, dbe_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        is_load, is_store, misalign, is_mem, exc_in, addr_fault, legal;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    case (aluop_i)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin
        is_load  = 1'b1;
        misalign = mem_addr_i[0];
      end
      OP_LW: begin
        is_load  = 1'b1;
        misalign = |mem_addr_i[1:0];
      end
      OP_SB: is_store = 1'b1;
      OP_SH: begin
        is_store = 1'b1;
        misalign = mem_addr_i[0];
      end
      OP_SW: begin
        is_store = 1'b1;
        misalign = |mem_addr_i[1:0];
      end
      default: ;
    endcase
  end

  assign is_mem     = is_load | is_store;
  assign exc_in     = exc_code_i != EC_NONE;
  assign addr_fault = is_mem & ~exc_in & misalign;
  assign legal      = is_mem & ~exc_in & ~misalign;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = reg2_i;
    case (aluop_i)
      OP_SB: begin
        be_calc    = 4'b0001 << mem_addr_i[1:0];
        wdata_calc = {4{reg2_i[7:0]}};
      end
      OP_SH: begin
        be_calc    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // EX/MEM is frozen during the access, so the address lane is still valid in DONE.
  assign ld_byte = 8'(rdata_q >> {mem_addr_i[1:0], 3'b000});
  assign ld_half = mem_addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    case (aluop_i)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'h0, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'h0, ld_half};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    dbe_d       = dbe_q;
    rdata_d     = rdata_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (legal && !flush_i) begin
          state_d     = StWait;
          cnt_d       = '0;
          abort_d     = 1'b0;
          dbe_d       = 1'b0;
          bus_addr_d  = {mem_addr_i[31:2], 2'b00};
          bus_we_d    = is_store;
          bus_be_d    = be_calc;
          bus_wdata_d = wdata_calc;
        end
      end
      StWait: begin
        // A flush cannot abandon the bus cycle; it only discards the result.
        abort_d = abort_q | flush_i;
        if (bus_ack_i) begin
          rdata_d = bus_rdata_i;
          state_d = abort_d ? StIdle : StDone;
        end else if (cnt_q == CntLast) begin
          dbe_d   = 1'b1;
          state_d = abort_d ? StIdle : StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      dbe_q       <= 1'b0;
      rdata_q     <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      dbe_q       <= dbe_d;
      rdata_q     <= rdata_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

  always_comb begin
    bus_req_o      = 1'b0;
    stall_req_o    = 1'b0;
    wd_o           = '0;
    wreg_o         = 1'b0;
    wdata_o        = '0;
    whilo_o        = 1'b0;
    hi_o           = '0;
    lo_o           = '0;
    cp0_we_o       = 1'b0;
    cp0_waddr_o    = '0;
    cp0_wdata_o    = '0;
    exc_code_o     = EC_NONE;
    exc_epc_o      = '0;
    exc_badvaddr_o = '0;
    if (!rst) begin
      wd_o           = wd_i;
      wreg_o         = wreg_i;
      wdata_o        = wdata_i;
      whilo_o        = whilo_i;
      hi_o           = hi_i;
      lo_o           = lo_i;
      cp0_we_o       = cp0_we_i;
      cp0_waddr_o    = cp0_waddr_i;
      cp0_wdata_o    = cp0_wdata_i;
      exc_code_o     = exc_code_i;
      exc_epc_o      = exc_epc_i;
      exc_badvaddr_o = exc_badvaddr_i;
      unique case (state_q)
        StIdle: begin
          if (addr_fault) begin
            exc_code_o     = is_load ? EC_ADEL : EC_ADES;
            exc_badvaddr_o = mem_addr_i;
            wreg_o         = 1'b0;
          end else if (legal && !flush_i) begin
            stall_req_o = 1'b1;
          end
        end
        StWait: begin
          bus_req_o   = 1'b1;
          stall_req_o = 1'b1;
        end
        StDone: begin
          if (is_load) wdata_o = load_data;
          if (dbe_q) begin
            exc_code_o     = EC_DBE;
            exc_badvaddr_o = mem_addr_i;
            wreg_o         = 1'b0;
          end
        end
        default: ;
      endcase
      if (stall_req_o || flush_i) begin
        wreg_o   = 1'b0;
        whilo_o  = 1'b0;
        cp0_we_o = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random accesses checked
// against an arithmetic model of the load/store lane rules.
module tb_mem_access;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [4:0] EC_NONE = 5'd31;
  localparam logic [4:0] EC_ADEL = 5'd4;
  localparam logic [4:0] EC_ADES = 5'd5;
  localparam logic [4:0] EC_DBE  = 5'd7;

  logic        clk = 1'b0;
  logic        rst, flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, hi_i, lo_i, cp0_wdata_i, exc_epc_i, exc_badvaddr_i;
  logic [4:0]  wd_i, cp0_waddr_i, exc_code_i;
  logic        wreg_i, whilo_i, cp0_we_i;
  logic        bus_req_o, bus_we_o, bus_ack_i, stall_req_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
  logic [4:0]  wd_o, cp0_waddr_o, exc_code_o;
  logic        wreg_o, whilo_o, cp0_we_o;
  logic [31:0] wdata_o, hi_o, lo_o, cp0_wdata_o, exc_epc_o, exc_badvaddr_o;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT(4), .EXC_CODE_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .whilo_i(whilo_i),
    .hi_i(hi_i), .lo_i(lo_i), .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i),
    .cp0_wdata_i(cp0_wdata_i), .exc_code_i(exc_code_i), .exc_epc_i(exc_epc_i),
    .exc_badvaddr_i(exc_badvaddr_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .stall_req_o(stall_req_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o),
    .lo_o(lo_o), .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
    .exc_code_o(exc_code_o), .exc_epc_o(exc_epc_o), .exc_badvaddr_o(exc_badvaddr_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_store_op(input logic [7:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * (addr % 4))) % 256;
    h = (rdata >> (16 * ((addr / 2) % 2))) % 65536;
    case (op)
      OP_LB:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      OP_LHU:  return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [7:0] op, input logic [31:0] addr);
    case (op)
      OP_SB:   return 4'(1 << (addr % 4));
      OP_SH:   return (addr % 4 >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] reg2);
    case (op)
      OP_SB:   return (reg2 % 256) * 32'h0101_0101;
      OP_SH:   return (reg2 % 65536) * 32'h0001_0001;
      default: return reg2;
    endcase
  endfunction

  // Full legal access: IDLE cycle, WAIT cycles with ack after `delay` cycles, DONE cycle.
  task automatic do_access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] rdata, input int delay);
    int stalls;
    bit st, acked;
    st = is_store_op(op);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = $urandom;
    wreg_i = 1'b1; wd_i = 5'($urandom); exc_code_i = EC_NONE; flush_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    chk("idle_stall", 32'(stall_req_o), 1);
    chk("idle_req", 32'(bus_req_o), 0);
    chk("idle_wreg_masked", 32'(wreg_o), 0);
    stalls = 1;
    tick();
    #1;
    chk("wait_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
    chk("wait_we", 32'(bus_we_o), 32'(st));
    chk("wait_be", 32'(bus_be_o), 32'(model_be(op, addr)));
    if (st) chk("wait_wdata", bus_wdata_o, model_wdata(op, reg2));
    acked = 1'b0;
    for (int n = 0; n < 20 && !acked; n++) begin
      if (n == delay) begin
        bus_ack_i = 1'b1;
        bus_rdata_i = rdata;
      end
      #1;
      chk("wait_req", 32'(bus_req_o), 1);
      if (stall_req_o) stalls++;
      if (n == delay) acked = 1'b1;
      tick();
      bus_ack_i = 1'b0;
      bus_rdata_i = $urandom;
    end
    #1;
    chk("done_stall", 32'(stall_req_o), 0);
    chk("done_req", 32'(bus_req_o), 0);
    chk("done_wreg", 32'(wreg_o), 1);
    chk("done_wdata", wdata_o, st ? wdata_i : model_load(op, addr, rdata));
    chk("done_exc", 32'(exc_code_o), 32'(EC_NONE));
    chk("stall_cycles", 32'(stalls), 32'(delay + 2));
    tick();
    aluop_i = OP_NOP;
  endtask

  initial begin
    logic [7:0] ops [8];
    int nreq;
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    // Reset with a legal access and live inputs: everything must read as zero.
    rst = 1'b1; flush_i = 1'b0; aluop_i = OP_LW; mem_addr_i = 32'h100; reg2_i = $urandom;
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = $urandom; whilo_i = 1'b1; hi_i = $urandom;
    lo_i = $urandom; cp0_we_i = 1'b1; cp0_waddr_i = 5'd9; cp0_wdata_i = $urandom;
    exc_code_i = EC_NONE; exc_epc_i = $urandom; exc_badvaddr_i = $urandom;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    tick(); tick();
    #1;
    chk("rst_req", 32'(bus_req_o), 0);
    chk("rst_stall", 32'(stall_req_o), 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_wreg", 32'(wreg_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_exc", 32'(exc_code_o), 32'(EC_NONE));
    rst = 1'b0; aluop_i = OP_NOP;
    tick();

    // Non-memory op passes through; flush masks the write enables only.
    #1;
    chk("pt_wd", 32'(wd_o), 32'(wd_i));
    chk("pt_wdata", wdata_o, wdata_i);
    chk("pt_hi", hi_o, hi_i);
    chk("pt_cp0_wdata", cp0_wdata_o, cp0_wdata_i);
    chk("pt_whilo", 32'(whilo_o), 1);
    flush_i = 1'b1;
    #1;
    chk("flush_wreg", 32'(wreg_o), 0);
    chk("flush_cp0_we", 32'(cp0_we_o), 0);
    chk("flush_lo", lo_o, lo_i);
    flush_i = 1'b0; whilo_i = 1'b0; cp0_we_i = 1'b0;
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    #1;
    chk("stray_ack_req", 32'(bus_req_o), 0);

    do_access(OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
    do_access(OP_LB, 32'h103, 32'h0, 32'h8011_2233, 0);
    do_access(OP_LBU, 32'h103, 32'h0, 32'h8011_2233, 0);
    do_access(OP_LH, 32'h102, 32'h0, 32'h8011_2233, 2);
    do_access(OP_SB, 32'h201, 32'h0000_00AB, 32'h0, 0);
    do_access(OP_SH, 32'h202, 32'h1234_5678, 32'h0, 3);

    // Alignment faults: no bus activity, no stall.
    aluop_i = OP_LW; mem_addr_i = 32'h102; exc_code_i = EC_NONE; wreg_i = 1'b1;
    #1;
    chk("adel_code", 32'(exc_code_o), 32'(EC_ADEL));
    chk("adel_badva", exc_badvaddr_o, 32'h102);
    chk("adel_stall", 32'(stall_req_o), 0);
    chk("adel_wreg", 32'(wreg_o), 0);
    tick();
    #1;
    chk("adel_no_req", 32'(bus_req_o), 0);
    aluop_i = OP_SH; mem_addr_i = 32'h101;
    #1;
    chk("ades_code", 32'(exc_code_o), 32'(EC_ADES));
    // Incoming exception outranks the alignment fault and blocks the access.
    exc_code_i = 5'd10;
    #1;
    chk("exc_pass_code", 32'(exc_code_o), 10);
    chk("exc_pass_badva", exc_badvaddr_o, exc_badvaddr_i);
    chk("exc_pass_stall", 32'(stall_req_o), 0);
    aluop_i = OP_LW; mem_addr_i = 32'h100;
    tick();
    #1;
    chk("exc_no_req", 32'(bus_req_o), 0);
    exc_code_i = EC_NONE; aluop_i = OP_NOP;
    tick();

    // Timeout: with TIMEOUT=4 the request is held exactly four cycles.
    aluop_i = OP_SW; mem_addr_i = 32'h300; reg2_i = $urandom;
    tick();
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!bus_req_o) break;
      nreq++;
      tick();
    end
    chk("to_req_cycles", 32'(nreq), 4);
    chk("to_code", 32'(exc_code_o), 32'(EC_DBE));
    chk("to_badva", exc_badvaddr_o, 32'h300);
    chk("to_wreg", 32'(wreg_o), 0);
    chk("to_stall", 32'(stall_req_o), 0);
    tick();
    aluop_i = OP_NOP;
    tick();

    // Flush during WAIT: finish the bus cycle, skip DONE.
    aluop_i = OP_LW; mem_addr_i = 32'h400;
    tick();
    flush_i = 1'b1;
    #1;
    chk("fl_req0", 32'(bus_req_o), 1);
    tick();
    flush_i = 1'b0;
    #1;
    chk("fl_req1", 32'(bus_req_o), 1);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    #1;
    chk("fl_ack_wreg", 32'(wreg_o), 0);
    tick();
    bus_ack_i = 1'b0;
    #1;
    // Back in IDLE with the load still presented, so a fresh stall appears instead of DONE.
    chk("fl_no_done_stall", 32'(stall_req_o), 1);
    chk("fl_no_done_wreg", 32'(wreg_o), 0);
    chk("fl_no_done_req", 32'(bus_req_o), 0);
    tick();
    #1;
    chk("rw_req", 32'(bus_req_o), 1);
    rst = 1'b1;
    #1;
    chk("rw_req_drop", 32'(bus_req_o), 0);
    tick();
    rst = 1'b0; aluop_i = OP_NOP;
    #1;
    chk("rw_idle_req", 32'(bus_req_o), 0);
    chk("rw_idle_stall", 32'(stall_req_o), 0);
    chk("rw_idle_wreg", 32'(wreg_o), 1);
    tick();

    // Random legal accesses against the model.
    for (int k = 0; k < 24; k++) begin
      logic [7:0]  op;
      logic [31:0] addr;
      op = ops[$urandom_range(0, 7)];
      addr = $urandom;
      if (op == OP_LW || op == OP_SW) addr[1:0] = 2'b00;
      else if (op == OP_LH || op == OP_LHU || op == OP_SH) addr[0] = 1'b0;
      do_access(op, addr, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
